// File: rtl/product_accumulator.sv
// Accumulates a stream of 32-bit unsigned products into an ACC_W-bit sum and holds the result for a downstream handshake.
// Build option: define PRODUCT_ACC_SAT_EN to saturate the sum to all-ones on overflow instead of wrapping.
module product_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [31:0]      prod,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] term_cnt,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_inReady;
  logic             r_outValid;

  logic             w_accept;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_accNext;
  logic [ACC_W-1:0] w_zext;
  logic [CNT_W-1:0] w_cntNext;

  assign w_accept  = in_valid & r_inReady & (r_state != HOLD);
  assign w_zext    = {{(ACC_W-32){1'b0}}, prod};
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_zext};
  assign w_carry   = w_sum[ACC_W];
  assign w_cntNext = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef PRODUCT_ACC_SAT_EN
  // Once a sum has overflowed it stays pinned at all-ones until cleared.
  assign w_accNext = (w_carry | r_ovf) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_accNext = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
    end else if (clr) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_inReady <= 1'b1;
          if (w_accept) begin
            r_acc <= w_zext;
            r_cnt <= CNT_W'(1);
            r_ovf <= 1'b0;
            if (in_last) begin
              r_state    <= HOLD;
              r_inReady  <= 1'b0;
              r_outValid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          r_inReady <= 1'b1;
          if (w_accept) begin
            r_acc <= w_accNext;
            r_cnt <= w_cntNext;
            r_ovf <= r_ovf | w_carry;
            if (in_last) begin
              r_state    <= HOLD;
              r_inReady  <= 1'b0;
              r_outValid <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Result is frozen here; input beats are refused until the consumer takes it.
          if (out_ready) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign acc_out   = r_acc;
  assign term_cnt  = r_cnt;
  assign ovf       = r_ovf;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: a 40-bit and a 33-bit instance share one input stream.
// Honours PRODUCT_ACC_SAT_EN for the expected overflow behaviour.
module tb_product_accumulator;

  localparam logic [63:0] MASK40 = 64'h0000_00FF_FFFF_FFFF;
  localparam logic [63:0] MASK33 = 64'h0000_0001_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [31:0] prod;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic [39:0] acc_out;
  logic [9:0]  term_cnt;
  logic        ovf;
  logic        out_valid;

  logic        in_ready33;
  logic [32:0] acc_out33;
  logic [9:0]  term_cnt33;
  logic        ovf33;
  logic        out_valid33;

  typedef struct {
    logic [39:0] acc40;
    logic [32:0] acc33;
    logic [9:0]  cnt;
    logic        ovf40;
    logic        ovf33;
  } exp_t;

  exp_t        expQ[$];
  logic [63:0] mAcc40;
  logic [63:0] mAcc33;
  logic [9:0]  mCnt;
  logic        mOvf40;
  logic        mOvf33;
  logic        mBusy;

  int compCount;
  int failCount;

  product_accumulator #(.ACC_W(40), .CNT_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .prod(prod),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .acc_out(acc_out), .term_cnt(term_cnt), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  product_accumulator #(.ACC_W(33), .CNT_W(10)) dut33 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .prod(prod),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready33),
    .acc_out(acc_out33), .term_cnt(term_cnt33), .ovf(ovf33),
    .out_valid(out_valid33), .out_ready(out_ready)
  );

  // Free-running clock; stimulus and sampling both happen on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelBeat(input logic [31:0] p, input logic last);
    logic [64:0] s;
    exp_t e;
    if (!mBusy) begin
      mAcc40 = {32'h0, p};
      mAcc33 = {32'h0, p};
      mCnt   = 10'd1;
      mOvf40 = 1'b0;
      mOvf33 = 1'b0;
      mBusy  = 1'b1;
    end else begin
      s      = {1'b0, mAcc40} + {33'h0, p};
      mOvf40 = mOvf40 | s[40];
      mAcc40 = s[63:0] & MASK40;
      s      = {1'b0, mAcc33} + {33'h0, p};
      mOvf33 = mOvf33 | s[33];
      mAcc33 = s[63:0] & MASK33;
`ifdef PRODUCT_ACC_SAT_EN
      if (mOvf40) mAcc40 = MASK40;
      if (mOvf33) mAcc33 = MASK33;
`endif
      if (mCnt != 10'h3FF) mCnt = mCnt + 10'd1;
    end
    if (last) begin
      e.acc40 = mAcc40[39:0];
      e.acc33 = mAcc33[32:0];
      e.cnt   = mCnt;
      e.ovf40 = mOvf40;
      e.ovf33 = mOvf33;
      expQ.push_back(e);
      mBusy = 1'b0;
    end
  endtask

  // Drives one beat starting at a falling edge; returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic [31:0] p, input logic last);
    int waitCnt = 0;
    while (in_ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (in_ready !== 1'b1) begin
      compCount++; failCount++;
      $display("[TB] FAIL beat_wait: in_ready got %b required 1", in_ready);
      return;
    end
    prod = p; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    modelBeat(p, last);
  endtask

  // Waits for a result, compares both instances against the scoreboard and releases it.
  task automatic checkOutput(input string tag);
    int waitCnt = 0;
    exp_t e;
    while (out_valid !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    compCount++;
    if (out_valid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL %s out_valid: got %b required 1", tag, out_valid);
      return;
    end
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL %s scoreboard: got result required none pending", tag);
      return;
    end
    e = expQ.pop_front();
    compCount++; if (acc_out !== e.acc40) begin failCount++; $display("[TB] FAIL %s acc_out: got %h required %h", tag, acc_out, e.acc40); end
    compCount++; if (term_cnt !== e.cnt) begin failCount++; $display("[TB] FAIL %s term_cnt: got %0d required %0d", tag, term_cnt, e.cnt); end
    compCount++; if (ovf !== e.ovf40) begin failCount++; $display("[TB] FAIL %s ovf: got %b required %b", tag, ovf, e.ovf40); end
    compCount++; if (acc_out33 !== e.acc33) begin failCount++; $display("[TB] FAIL %s acc_out33: got %h required %h", tag, acc_out33, e.acc33); end
    compCount++; if (ovf33 !== e.ovf33) begin failCount++; $display("[TB] FAIL %s ovf33: got %b required %b", tag, ovf33, e.ovf33); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    compCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL %s release_valid: got %b required 0", tag, out_valid); end
    compCount++; if (acc_out !== 40'h0 || term_cnt !== 10'h0 || ovf !== 1'b0) begin failCount++; $display("[TB] FAIL %s release_clear: got %h/%0d/%b required 0/0/0", tag, acc_out, term_cnt, ovf); end
    compCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL %s release_ready: got %b required 1", tag, in_ready); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    compCount++; if (acc_out !== 40'h0 || term_cnt !== 10'h0 || ovf !== 1'b0) begin failCount++; $display("[TB] FAIL reset_regs: got %h/%0d/%b required 0/0/0", acc_out, term_cnt, ovf); end
    compCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b required 0", out_valid); end
    compCount++; if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ready: got %b required 0", in_ready); end
    rst_n = 1'b1;
    #1;
    compCount++; if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL release_before_edge_ready: got %b required 0", in_ready); end
    @(negedge clk);
    compCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL release_after_edge_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_single();
    applyStimulus(32'h0000_0001, 1'b1);
    compCount++; if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL single_latency: got %b required 1", out_valid); end
    compCount++; if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL single_hold_ready: got %b required 0", in_ready); end
    checkOutput("single");
  endtask

  task automatic test_gapped();
    logic [31:0] terms [4];
    terms[0] = 32'h1234_5678; terms[1] = 32'h0000_FFFF;
    terms[2] = 32'hFFFE_0001; terms[3] = 32'h0000_0002;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(terms[i], i == 3);
      if (i == 1) begin
        compCount++; if (acc_out !== mAcc40[39:0] || term_cnt !== 10'd2) begin failCount++; $display("[TB] FAIL partial_sum: got %h/%0d required %h/2", acc_out, term_cnt, mAcc40[39:0]); end
      end
      if (i < 3) @(negedge clk);
    end
    checkOutput("gapped");
  endtask

  task automatic test_backpressure();
    applyStimulus(32'h0000_0005, 1'b1);
    prod = 32'd99; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compCount++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== 40'd5 || term_cnt !== 10'd1) begin failCount++; $display("[TB] FAIL bp_frozen%0d: got v%b r%b %h/%0d required v1 r0 5/1", i, out_valid, in_ready, acc_out, term_cnt); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    expQ.delete();
    compCount++; if (out_valid !== 1'b0 || acc_out !== 40'h0 || in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL bp_release: got v%b %h r%b required v0 0 r1", out_valid, acc_out, in_ready); end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    modelBeat(32'd99, 1'b1);
    checkOutput("bp_new_sum");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) applyStimulus(32'hFFFE_0001, i == 2);
    @(negedge clk);
    compCount++; if (ovf33 !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_sticky_hold: got %b required 1", ovf33); end
    checkOutput("overflow");
  endtask

  task automatic test_cnt_saturate();
    for (int i = 0; i < 1030; i++) applyStimulus(32'h0000_0001, i == 1029);
    checkOutput("cnt_saturate");
  endtask

  task automatic test_abort();
    applyStimulus(32'h0000_0010, 1'b0);
    applyStimulus(32'h0000_0020, 1'b0);
    clr = 1'b1; prod = 32'h0000_0030; in_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    mBusy = 1'b0;
    compCount++; if (acc_out !== 40'h0 || term_cnt !== 10'h0 || ovf !== 1'b0) begin failCount++; $display("[TB] FAIL abort_clear: got %h/%0d/%b required 0/0/0", acc_out, term_cnt, ovf); end
    compCount++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL abort_idle: got r%b v%b required r1 v0", in_ready, out_valid); end
    applyStimulus(32'h0000_0044, 1'b1);
    checkOutput("after_abort");
  endtask

  task automatic test_async_reset();
    applyStimulus(32'h0000_0003, 1'b0);
    applyStimulus(32'h0000_0004, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    compCount++; if (acc_out !== 40'h0 || term_cnt !== 10'h0 || in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL async_mid_sum: got %h/%0d r%b required 0/0 r0", acc_out, term_cnt, in_ready); end
    mBusy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(32'h0000_0009, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    compCount++; if (out_valid !== 1'b0 || acc_out !== 40'h0 || term_cnt !== 10'h0) begin failCount++; $display("[TB] FAIL async_hold: got v%b %h/%0d required v0 0/0", out_valid, acc_out, term_cnt); end
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(32'h0000_0003, 1'b0);
    applyStimulus(32'h0000_0004, 1'b1);
    compCount++; if (acc_out !== 40'd7) begin failCount++; $display("[TB] FAIL fresh_sum: got %h required 7", acc_out); end
    checkOutput("after_reset");
  endtask

  initial begin
    compCount = 0; failCount = 0;
    rst_n = 1'b0; clr = 1'b0; prod = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    mAcc40 = '0; mAcc33 = '0; mCnt = '0; mOvf40 = 1'b0; mOvf33 = 1'b0; mBusy = 1'b0;
    test_reset();
    test_single();
    test_gapped();
    test_backpressure();
    test_overflow();
    test_abort();
    test_async_reset();
    test_cnt_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
